// File: rtl/bus_arbiter_if.sv
// Shared-bus arbiter interface: master-side request/strobe bundle and
// the slave-side shared bus. The arbiter connects through the slave
// modport; the bus masters (or a bench) drive through the master modport.
interface bus_arbiter_if #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
);
    logic [3:0]          m_req_;
    logic [3:0]          m_grnt_;
    logic [3:0]          m_as_;
    logic [3:0]          m_rw;
    logic [4*ADDR_W-1:0] m_addr;
    logic [4*DATA_W-1:0] m_wr_data;
    logic [3:0]          m_rdy_;
    logic [DATA_W-1:0]   m_rd_data;
    logic                s_as_;
    logic                s_rw;
    logic [ADDR_W-1:0]   s_addr;
    logic [DATA_W-1:0]   s_wr_data;
    logic                s_rdy_;
    logic [DATA_W-1:0]   s_rd_data;
    logic                arb_timeout;

    modport master (
        output m_req_, m_as_, m_rw, m_addr, m_wr_data, s_rdy_, s_rd_data,
        input  m_grnt_, m_rdy_, m_rd_data, s_as_, s_rw, s_addr, s_wr_data,
               arb_timeout
    );

    modport slave (
        input  m_req_, m_as_, m_rw, m_addr, m_wr_data, s_rdy_, s_rd_data,
        output m_grnt_, m_rdy_, m_rd_data, s_as_, s_rw, s_addr, s_wr_data,
               arb_timeout
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter and multiplexer for the shared peripheral bus.
// Four active-low requesters, one registered grant at a time; the owner's
// strobes drive the shared bus and the slave's rdy_ is routed back to it.
// Optional feature macro: BUS_ARB_TIMEOUT_EN (forced grant revocation after
// MAX_HOLD cycles of continuous ownership).
module bus_arbiter #(
    parameter int ADDR_W   = 30,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 256
) (
    input  logic          clk,
    input  logic          reset,
    bus_arbiter_if.slave  bus
);

    typedef enum logic {ST_IDLE, ST_OWNED} state_t;

    state_t     r_state, w_state_nxt;
    logic [1:0] r_owner, w_owner_nxt;
    logic [1:0] r_last,  w_last_nxt;
    logic [3:0] r_grnt_;
    logic       r_timeout, w_timeout_nxt;
    logic       w_found;
    logic [1:0] w_pick;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    logic [CNT_W-1:0] r_hold, w_hold_nxt;
`endif

    // Round-robin scan: first requester after the last owner, wrapping mod 4.
    always_comb begin
        logic [1:0] v_idx;
        w_found = 1'b0;
        w_pick  = r_last;
        for (int unsigned k = 1; k <= 4; k++) begin
            v_idx = r_last + 2'(k);
            if (!w_found && !bus.m_req_[v_idx]) begin
                w_found = 1'b1;
                w_pick  = v_idx;
            end
        end
    end

    // Next-state: keep a still-requesting owner, else hand over in RR order.
    always_comb begin
        w_state_nxt   = r_state;
        w_owner_nxt   = r_owner;
        w_last_nxt    = r_last;
        w_timeout_nxt = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
        w_hold_nxt    = r_hold;
`endif
        if (r_state == ST_OWNED && !bus.m_req_[r_owner]) begin
`ifdef BUS_ARB_TIMEOUT_EN
            if (r_hold == CNT_W'(MAX_HOLD - 1)) begin
                // Revoked master becomes last-owner so others win next.
                w_state_nxt   = ST_IDLE;
                w_last_nxt    = r_owner;
                w_timeout_nxt = 1'b1;
                w_hold_nxt    = '0;
            end else begin
                w_hold_nxt = r_hold + 1'b1;
            end
`endif
        end else if (w_found) begin
            w_state_nxt = ST_OWNED;
            w_owner_nxt = w_pick;
            w_last_nxt  = w_pick;
`ifdef BUS_ARB_TIMEOUT_EN
            w_hold_nxt  = '0;
`endif
        end else begin
            w_state_nxt = ST_IDLE;
        end
    end

    // State, grant and timeout-pulse registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_owner   <= 2'd0;
            r_last    <= 2'd3;
            r_grnt_   <= '1;
            r_timeout <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
            r_hold    <= '0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_owner   <= w_owner_nxt;
            r_last    <= w_last_nxt;
            r_grnt_   <= (w_state_nxt == ST_OWNED) ? ~(4'b0001 << w_owner_nxt) : 4'b1111;
            r_timeout <= w_timeout_nxt;
`ifdef BUS_ARB_TIMEOUT_EN
            r_hold    <= w_hold_nxt;
`endif
        end
    end

    // Shared-bus mux from the registered owner; idle bus parks high/zero.
    always_comb begin
        bus.s_as_     = 1'b1;
        bus.s_rw      = 1'b1;
        bus.s_addr    = '0;
        bus.s_wr_data = '0;
        bus.m_rdy_    = '1;
        if (r_state == ST_OWNED) begin
            bus.s_as_            = bus.m_as_[r_owner];
            bus.s_rw             = bus.m_rw[r_owner];
            bus.s_addr           = bus.m_addr[int'(r_owner)*ADDR_W +: ADDR_W];
            bus.s_wr_data        = bus.m_wr_data[int'(r_owner)*DATA_W +: DATA_W];
            bus.m_rdy_[r_owner]  = bus.s_rdy_;
        end
    end

    assign bus.m_grnt_    = r_grnt_;
    assign bus.m_rd_data  = bus.s_rd_data;
`ifdef BUS_ARB_TIMEOUT_EN
    assign bus.arb_timeout = r_timeout;
`else
    assign bus.arb_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter.
module tb_bus_arbiter;

    localparam int AW = 30;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    initial begin
        reset            = 1'b1;
        bus.m_req_       = 4'b0000;
        bus.m_as_        = 4'b1111;
        bus.m_rw         = 4'b1111;
        bus.m_addr       = '0;
        bus.m_wr_data    = '0;
        bus.s_rdy_       = 1'b1;
        bus.s_rd_data    = '0;

        // 1: reset with everyone requesting
        tick();
        tick();
        check("rst_grnt",    64'(bus.m_grnt_), 64'hF);
        check("rst_as",      64'(bus.s_as_), 64'h1);
        check("rst_addr",    64'(bus.s_addr), 64'h0);
        check("rst_rdy",     64'(bus.m_rdy_), 64'hF);
        check("rst_tmo",     64'(bus.arb_timeout), 64'h0);
        reset = 1'b0;
        tick();
        check("first_grnt",  64'(bus.m_grnt_), 64'hE);

        // 2: round-robin handover with no idle gap
        bus.m_req_ = 4'b0001; tick();
        check("rr_1", 64'(bus.m_grnt_), 64'hD);
        bus.m_req_ = 4'b0010; tick();
        check("rr_2", 64'(bus.m_grnt_), 64'hB);
        bus.m_req_ = 4'b0100; tick();
        check("rr_3", 64'(bus.m_grnt_), 64'h7);
        bus.m_req_ = 4'b1000; tick();
        check("rr_0", 64'(bus.m_grnt_), 64'hE);

        // 3: master 2 read through the mux, master 0 strobe ignored
        bus.m_req_ = 4'b1011; tick();
        check("m2_grnt", 64'(bus.m_grnt_), 64'hB);
        bus.m_as_                      = 4'b1010;
        bus.m_rw                       = 4'b0100;
        bus.m_addr[2*AW +: AW]         = 30'h10;
        bus.m_addr[0 +: AW]            = 30'h3FF;
        bus.m_wr_data[2*DW +: DW]      = 32'hA5A5_0002;
        bus.m_wr_data[0 +: DW]         = 32'h1234_0000;
        bus.s_rdy_                     = 1'b0;
        bus.s_rd_data                  = 32'h5;
        #1;
        check("m2_addr",   64'(bus.s_addr), 64'h10);
        check("m2_as",     64'(bus.s_as_), 64'h0);
        check("m2_rw",     64'(bus.s_rw), 64'h1);
        check("m2_wdata",  64'(bus.s_wr_data), 64'hA5A5_0002);
        check("m2_rdy",    64'(bus.m_rdy_), 64'hB);
        check("m2_rdata",  64'(bus.m_rd_data), 64'h5);
        bus.m_as_ = 4'b1110; #1;
        check("m0_as_ign", 64'(bus.s_as_), 64'h1);
        bus.s_rdy_ = 1'b1;
        bus.m_as_  = 4'b1111;

        // 4: reset in the middle of a master 1 transfer
        bus.m_req_ = 4'b1101; tick();
        check("m1_grnt", 64'(bus.m_grnt_), 64'hD);
        bus.m_as_ = 4'b1101; #1;
        check("m1_as",   64'(bus.s_as_), 64'h0);
        reset = 1'b1; tick();
        check("mid_rst_grnt", 64'(bus.m_grnt_), 64'hF);
        check("mid_rst_as",   64'(bus.s_as_), 64'h1);
        reset = 1'b0; tick();
        check("post_rst_grnt", 64'(bus.m_grnt_), 64'hD);
        bus.m_as_ = 4'b1111;

        // release, then master 0 alone; master 3 joins while 0 holds
        bus.m_req_ = 4'b1111; tick();
        check("idle_grnt", 64'(bus.m_grnt_), 64'hF);
        bus.m_req_ = 4'b1110; tick();
        check("hold_grnt0", 64'(bus.m_grnt_), 64'hE);
        bus.m_req_ = 4'b0110;

`ifdef BUS_ARB_TIMEOUT_EN
        // 5: forced revocation after 8 grant cycles
        for (int i = 0; i < 7; i++) begin
            tick();
            check("tmo_hold", 64'(bus.m_grnt_), 64'hE);
            check("tmo_quiet", 64'(bus.arb_timeout), 64'h0);
        end
        tick();
        check("tmo_revoke", 64'(bus.m_grnt_), 64'hF);
        check("tmo_pulse",  64'(bus.arb_timeout), 64'h1);
        tick();
        check("tmo_next",   64'(bus.m_grnt_), 64'h7);
        check("tmo_clear",  64'(bus.arb_timeout), 64'h0);
`else
        // 6: no timeout, master 0 keeps the grant indefinitely
        for (int i = 0; i < 1000; i++) begin
            tick();
            check("keep_grnt", 64'(bus.m_grnt_), 64'hE);
            check("keep_tmo",  64'(bus.arb_timeout), 64'h0);
        end
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
